// File: rtl/filt_pkg.sv
`default_nettype none
// ============================================================================
// Module      : filt_pkg
// Description : Shared types and constants for the filter tap sequencer.
// Revision    : 1.0  initial release
// ============================================================================
package filt_pkg;

  localparam int TAPS   = 4;
  localparam int SEL_W  = 2;
  localparam int FILL_W = 3;

  typedef logic [SEL_W-1:0] tap_sel_t;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_e;

  // Highest select value; the scan of one sample ends here.
  localparam tap_sel_t c_SEL_LAST = tap_sel_t'(TAPS - 1);

endpackage : filt_pkg
`default_nettype wire

// File: rtl/tap_delay_line.sv
`default_nettype none
// ============================================================================
// Module      : tap_delay_line
// Description : 4-stage sample shift register with shift enable and
//               synchronous clear. d0_o is the newest sample, d3_o the oldest.
// Revision    : 1.0  initial release
// ============================================================================
module tap_delay_line #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_i,
  input  logic             shift_en_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] d0_o,
  output logic [WIDTH-1:0] d1_o,
  output logic [WIDTH-1:0] d2_o,
  output logic [WIDTH-1:0] d3_o
);

  logic [WIDTH-1:0] d0_q, d1_q, d2_q, d3_q;
  logic [WIDTH-1:0] d0_d, d1_d, d2_d, d3_d;

  // Next contents: clear wins over shift, otherwise hold.
  always_comb begin
    d0_d = d0_q;
    d1_d = d1_q;
    d2_d = d2_q;
    d3_d = d3_q;
    if (clear_i) begin
      d0_d = '0;
      d1_d = '0;
      d2_d = '0;
      d3_d = '0;
    end else if (shift_en_i) begin
      d0_d = data_i;
      d1_d = d0_q;
      d2_d = d1_q;
      d3_d = d2_q;
    end
  end

  // Delay-line storage with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d0_q <= '0;
      d1_q <= '0;
      d2_q <= '0;
      d3_q <= '0;
    end else begin
      d0_q <= d0_d;
      d1_q <= d1_d;
      d2_q <= d2_d;
      d3_q <= d3_d;
    end
  end

  assign d0_o = d0_q;
  assign d1_o = d1_q;
  assign d2_o = d2_q;
  assign d3_o = d3_q;

endmodule : tap_delay_line
`default_nettype wire

// File: rtl/filter_tap_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : filter_tap_sequencer
// Description : Feeds a 4-to-1 tap multiplexer: keeps a 4-deep sample delay
//               line and steps the select through taps 0..3 once per accepted
//               sample, stalling on out_ready.
// Revision    : 1.0  initial release
// ============================================================================
module filter_tap_sequencer
  import filt_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int TAPS  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic [WIDTH-1:0] d0,
  output logic [WIDTH-1:0] d1,
  output logic [WIDTH-1:0] d2,
  output logic [WIDTH-1:0] d3,
  output logic             s0,
  output logic             s1,
  input  logic             out_ready,
  output logic             tap_valid,
  output logic             tap_last,
  output logic             primed
);

  // The select is 2 bits wide, so only a 4-tap configuration is meaningful.
  if (TAPS != 4) begin : g_taps_check
    $error("filter_tap_sequencer: TAPS must be 4");
  end

  localparam logic [FILL_W-1:0] c_FILL_FULL = FILL_W'(TAPS);

  state_e            state_q, state_d;
  tap_sel_t          sel_q, sel_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic              w_accept;

  // State, select and fill-count registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= '0;
      fill_q  <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      fill_q  <= fill_d;
    end
  end

  // Next-state logic: flush dominates, then scan stepping and accepts.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    fill_d  = fill_q;
    if (flush) begin
      state_d = IDLE;
      sel_d   = '0;
      fill_d  = '0;
    end else begin
      if (w_accept && (fill_q != c_FILL_FULL)) begin
        fill_d = fill_q + 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (w_accept) begin
            state_d = SCAN;
            sel_d   = '0;
          end
        end
        SCAN: begin
          if (out_ready) begin
            if (sel_q != c_SEL_LAST) begin
              sel_d = sel_q + 1'b1;
            end else begin
              // Back-to-back accept restarts the scan without an idle gap.
              sel_d   = '0;
              state_d = w_accept ? SCAN : IDLE;
            end
          end
        end
        default: begin
          state_d = IDLE;
          sel_d   = '0;
        end
      endcase
    end
  end

  // Outputs: handshake ready depends on out_ready and flush only, never in_valid.
  always_comb begin
    in_ready  = 1'b0;
    tap_valid = 1'b0;
    tap_last  = 1'b0;
    if (!flush) begin
      in_ready = (state_q == IDLE) ||
                 ((sel_q == c_SEL_LAST) && out_ready);
    end
    if (state_q == SCAN) begin
      tap_valid = 1'b1;
      tap_last  = (sel_q == c_SEL_LAST);
    end
  end

  assign w_accept = in_valid & in_ready;
  assign s0       = sel_q[0];
  assign s1       = sel_q[1];
  assign primed   = (fill_q == c_FILL_FULL);

  tap_delay_line #(
    .WIDTH (WIDTH)
  ) u_delay_line (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear_i    (flush),
    .shift_en_i (w_accept),
    .data_i     (in_data),
    .d0_o       (d0),
    .d1_o       (d1),
    .d2_o       (d2),
    .d3_o       (d3)
  );

endmodule : filter_tap_sequencer
`default_nettype wire

// File: tb/tb_filter_tap_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_filter_tap_sequencer
// Description : Self-checking bench for filter_tap_sequencer (WIDTH=8).
//               Each accepted sample queues its four expected select values;
//               entries retire as the downstream consumes taps.
// Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_filter_tap_sequencer;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_data = '0;
  logic [WIDTH-1:0] d0, d1, d2, d3;
  logic             s0, s1;
  logic             out_ready = 1'b1;
  logic             tap_valid, tap_last, primed;

  int n_checks = 0;
  int n_fails  = 0;

  // Scoreboard: pending select values, shadow delay line, fill count.
  int               exp_q[$];
  logic [WIDTH-1:0] sh[4];
  int               fill = 0;

  filter_tap_sequencer #(.WIDTH(WIDTH), .TAPS(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .d0        (d0),
    .d1        (d1),
    .d2        (d2),
    .d3        (d3),
    .s0        (s0),
    .s1        (s1),
    .out_ready (out_ready),
    .tap_valid (tap_valid),
    .tap_last  (tap_last),
    .primed    (primed)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    for (int i = 0; i < 4; i++) sh[i] = '0;
    fill = 0;
  endtask

  // Per-cycle monitor: compare against the scoreboard, then advance it for the coming edge.
  always @(negedge clk) begin
    if (rst_n) begin
      logic exp_rdy;
      int   exp_sel;
      exp_rdy = !flush && ((exp_q.size() == 0) || ((exp_q.size() == 1) && out_ready));
      exp_sel = (exp_q.size() != 0) ? exp_q[0] : 0;
      check_eq("in_ready", in_ready, exp_rdy);
      check_eq("tap_valid", tap_valid, exp_q.size() != 0);
      check_eq("sel", {s1, s0}, exp_sel);
      check_eq("tap_last", tap_last, (exp_q.size() != 0) && (exp_sel == 3));
      check_eq("d0", d0, sh[0]);
      check_eq("d1", d1, sh[1]);
      check_eq("d2", d2, sh[2]);
      check_eq("d3", d3, sh[3]);
      check_eq("primed", primed, fill >= 4);
      if (flush) begin
        model_clear();
      end else begin
        if (out_ready && exp_q.size() != 0) void'(exp_q.pop_front());
        if (in_valid && exp_rdy) begin
          sh[3] = sh[2]; sh[2] = sh[1]; sh[1] = sh[0]; sh[0] = in_data;
          for (int k = 0; k < 4; k++) exp_q.push_back(k);
          if (fill < 4) fill++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a sample until the DUT takes it; returns just after the accepting edge.
  task automatic push(input logic [WIDTH-1:0] v);
    logic taken;
    taken = 1'b0;
    in_valid = 1'b1;
    in_data  = v;
    for (int n = 0; n < 40 && !taken; n++) begin
      @(negedge clk);
      taken = in_ready;
      tick();
    end
    if (!taken) check_eq("push_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (tap_valid && n < 40) begin
      tick();
      n++;
    end
    if (tap_valid) check_eq("idle_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    model_clear();
    tick();
    // Reset values while rst_n is low.
    check_eq("rst_d0", d0, 0);
    check_eq("rst_d3", d3, 0);
    check_eq("rst_sel", {s1, s0}, 0);
    check_eq("rst_tap_valid", tap_valid, 0);
    check_eq("rst_primed", primed, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Single sample, no stalls.
    push(8'h11);
    check_eq("single_d0", d0, 8'h11);
    check_eq("single_d1", d1, 8'h00);
    wait_idle();
    tick();

    // Four samples back to back.
    push(8'h11);
    push(8'h22);
    push(8'h33);
    push(8'h44);
    check_eq("b2b_d0", d0, 8'h44);
    check_eq("b2b_d1", d1, 8'h33);
    check_eq("b2b_d2", d2, 8'h22);
    check_eq("b2b_d3", d3, 8'h11);
    check_eq("b2b_primed", primed, 1);
    wait_idle();

    // Stall at sel=1 for three cycles.
    push(8'h55);
    tick();
    check_eq("stall_pre_sel", {s1, s0}, 1);
    out_ready = 1'b0;
    repeat (3) tick();
    check_eq("stall_sel", {s1, s0}, 1);
    check_eq("stall_ready", in_ready, 0);
    out_ready = 1'b1;
    tick();
    check_eq("stall_resume_sel", {s1, s0}, 2);
    wait_idle();

    // Flush at sel=2 with a sample offered.
    push(8'h66);
    tick();
    tick();
    check_eq("flush_pre_sel", {s1, s0}, 2);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h77;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    check_eq("flush_tap_valid", tap_valid, 0);
    check_eq("flush_d0", d0, 0);
    check_eq("flush_primed", primed, 0);
    tick();

    // Asynchronous reset in the middle of a scan.
    push(8'h88);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_d0", d0, 0);
    check_eq("arst_tap_valid", tap_valid, 0);
    check_eq("arst_sel", {s1, s0}, 0);
    model_clear();
    tick();
    rst_n = 1'b1;
    check_eq("arst_in_ready", in_ready, 1);
    push(8'hA5);
    check_eq("post_rst_d0", d0, 8'hA5);
    check_eq("post_rst_d1", d1, 8'h00);
    check_eq("post_rst_d3", d3, 8'h00);
    wait_idle();

    // Offer at sel=3 while downstream stalls; accept only when out_ready rises.
    push(8'h10);
    repeat (3) tick();
    check_eq("sel3_sel", {s1, s0}, 3);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'h20;
    repeat (2) tick();
    check_eq("sel3_hold_d0", d0, 8'h10);
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    check_eq("sel3_acc_d0", d0, 8'h20);
    check_eq("sel3_acc_d1", d1, 8'h10);
    wait_idle();
    repeat (2) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule : tb_filter_tap_sequencer
`default_nettype wire
